// File: rtl/motor_link_pkg.sv
// ============================================================================
// Module  : motor_link_pkg
// Brief   : Shared constants and state encoding for the motorboard command link.
// Revision: 1.0
// ============================================================================
`default_nettype none

package motor_link_pkg;

    localparam int          PAYLOAD_BYTES = 16;
    localparam int          FRAME_BYTES   = PAYLOAD_BYTES + 2;
    localparam logic [15:0] CRC_POLY      = 16'h1021;
    localparam logic [15:0] CRC_INIT      = 16'hFFFF;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LEAD      = 4'd1,
        ST_SEND      = 4'd2,
        ST_SEND_WAIT = 4'd3,
        ST_TRAIL     = 4'd4,
        ST_WAIT_RESP = 4'd5,
        ST_RECV      = 4'd6,
        ST_DONE      = 4'd7,
        ST_FAIL      = 4'd8
    } link_state_e;

endpackage

`default_nettype wire

// File: rtl/crc16_ccitt_byte.sv
// ============================================================================
// Module  : crc16_ccitt_byte
// Brief   : Combinational CRC-16/CCITT-FALSE update by one byte, MSB first.
// Revision: 1.0
// ============================================================================
`default_nettype none

module crc16_ccitt_byte
    import motor_link_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_v;

    always_comb begin
        crc_v = crc_i ^ {data_i, 8'h00};
        for (int b = 0; b < 8; b++) begin
            crc_v = crc_v[15] ? ({crc_v[14:0], 1'b0} ^ CRC_POLY) : {crc_v[14:0], 1'b0};
        end
        crc_o = crc_v;
    end

endmodule

`default_nettype wire

// File: rtl/motor_link_master.sv
// ============================================================================
// Module  : motor_link_master
// Brief   : Host end of the motorboard link: framed command send with CRC-16,
//           framed response receive with timeout. LINK_RESP_CRC_EN enables the
//           response CRC check.
// Revision: 1.0
// ============================================================================
`default_nettype none

module motor_link_master #(
    parameter int PAYLOAD_BYTES  = motor_link_pkg::PAYLOAD_BYTES,
    parameter int GUARD_CYCLES   = 32,
    parameter int TIMEOUT_CYCLES = 16000
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [8*PAYLOAD_BYTES-1:0] cmd_payload,
    output logic                       frame_n,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_active,
    input  logic                       tx_done,
    input  logic                       rx_data_ready,
    input  logic [7:0]                 rx_data,
    input  logic                       resp_frame_n,
    output logic                       resp_valid,
    output logic [8*PAYLOAD_BYTES-1:0] resp_payload,
    output logic                       resp_crc_ok,
    output logic                       resp_timeout,
    output logic                       busy
);

    import motor_link_pkg::*;

    localparam int FRAME_LEN = PAYLOAD_BYTES + 2;
    localparam int IW        = $clog2(FRAME_LEN + 1);
    localparam int TMAX      = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
    localparam int TW        = $clog2(TMAX + 1);

    link_state_e               state_q, state_d;
    logic                      frame_n_q, frame_n_d;
    logic                      tx_start_q, tx_start_d;
    logic [7:0]                tx_data_q, tx_data_d;
    logic [8*PAYLOAD_BYTES-1:0] payload_q, payload_d;
    logic [8*PAYLOAD_BYTES-1:0] rx_buf_q, rx_buf_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic [15:0]               tx_crc_q, tx_crc_d;
    logic                      resp_valid_q, resp_valid_d;
    logic [8*PAYLOAD_BYTES-1:0] resp_payload_q, resp_payload_d;
    logic                      resp_crc_ok_q, resp_crc_ok_d;
    logic                      resp_timeout_q, resp_timeout_d;
    logic [1:0]                sync_q;
    logic                      resp_frame_s;
    logic [7:0]                tx_byte;
    logic [15:0]               tx_crc_next;

    assign resp_frame_s = sync_q[1];

    // tx_data_q holds the byte in flight, so the fold on tx_done sees it unchanged
    crc16_ccitt_byte u_tx_crc (
        .crc_i  (tx_crc_q),
        .data_i (tx_data_q),
        .crc_o  (tx_crc_next)
    );

`ifdef LINK_RESP_CRC_EN
    logic [15:0] rx_crc_q, rx_crc_d;
    logic [15:0] rx_rcv_q, rx_rcv_d;
    logic [15:0] rx_crc_next;

    crc16_ccitt_byte u_rx_crc (
        .crc_i  (rx_crc_q),
        .data_i (rx_data),
        .crc_o  (rx_crc_next)
    );
`endif

    always_comb begin
        tx_byte = 8'h00;
        if (idx_q < IW'(PAYLOAD_BYTES)) begin
            tx_byte = payload_q[idx_q*8 +: 8];
        end else if (idx_q == IW'(PAYLOAD_BYTES)) begin
            tx_byte = tx_crc_q[15:8];
        end else begin
            tx_byte = tx_crc_q[7:0];
        end
    end

    always_comb begin
        state_d        = state_q;
        frame_n_d      = frame_n_q;
        tx_start_d     = 1'b0;
        tx_data_d      = tx_data_q;
        payload_d      = payload_q;
        rx_buf_d       = rx_buf_q;
        idx_d          = idx_q;
        timer_d        = timer_q;
        tx_crc_d       = tx_crc_q;
        resp_valid_d   = 1'b0;
        resp_payload_d = resp_payload_q;
        resp_crc_ok_d  = resp_crc_ok_q;
        resp_timeout_d = resp_timeout_q;
`ifdef LINK_RESP_CRC_EN
        rx_crc_d       = rx_crc_q;
        rx_rcv_d       = rx_rcv_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    payload_d = cmd_payload;
                    tx_crc_d  = CRC_INIT;
                    idx_d     = '0;
                    timer_d   = '0;
                    frame_n_d = 1'b0;
                    state_d   = ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (timer_q == TW'(GUARD_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = ST_SEND;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_SEND: begin
                if (!tx_active) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = tx_byte;
                    state_d    = ST_SEND_WAIT;
                end
            end
            ST_SEND_WAIT: begin
                if (tx_done) begin
                    if (idx_q < IW'(PAYLOAD_BYTES)) begin
                        tx_crc_d = tx_crc_next;
                    end
                    if (idx_q == IW'(FRAME_LEN - 1)) begin
                        // the tx_done cycle is the first trailing guard cycle
                        timer_d = TW'(1);
                        state_d = ST_TRAIL;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = ST_SEND;
                    end
                end
            end
            ST_TRAIL: begin
                if (timer_q == TW'(GUARD_CYCLES - 1)) begin
                    frame_n_d = 1'b1;
                    timer_d   = '0;
                    state_d   = ST_WAIT_RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_WAIT_RESP: begin
                if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    resp_valid_d   = 1'b1;
                    resp_timeout_d = 1'b1;
                    resp_crc_ok_d  = 1'b0;
                    state_d        = ST_FAIL;
                end else if (!resp_frame_s) begin
                    idx_d    = '0;
                    timer_d  = '0;
`ifdef LINK_RESP_CRC_EN
                    rx_crc_d = CRC_INIT;
`endif
                    state_d  = ST_RECV;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_RECV: begin
                if (idx_q == IW'(FRAME_LEN)) begin
                    resp_valid_d   = 1'b1;
                    resp_payload_d = rx_buf_q;
                    resp_timeout_d = 1'b0;
`ifdef LINK_RESP_CRC_EN
                    resp_crc_ok_d  = (rx_rcv_q == rx_crc_q);
`else
                    resp_crc_ok_d  = 1'b1;
`endif
                    state_d        = ST_DONE;
                end else if (rx_data_ready) begin
                    if (idx_q < IW'(PAYLOAD_BYTES)) begin
                        rx_buf_d[idx_q*8 +: 8] = rx_data;
                    end
`ifdef LINK_RESP_CRC_EN
                    if (idx_q < IW'(PAYLOAD_BYTES)) begin
                        rx_crc_d = rx_crc_next;
                    end else begin
                        rx_rcv_d = {rx_rcv_q[7:0], rx_data};
                    end
`endif
                    idx_d   = idx_q + IW'(1);
                    timer_d = '0;
                end else if (resp_frame_s || (timer_q == TW'(TIMEOUT_CYCLES - 1))) begin
                    resp_valid_d   = 1'b1;
                    resp_timeout_d = 1'b1;
                    resp_crc_ok_d  = 1'b0;
                    state_d        = ST_FAIL;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_FAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q        <= ST_IDLE;
            frame_n_q      <= 1'b1;
            tx_start_q     <= 1'b0;
            tx_data_q      <= 8'h00;
            payload_q      <= '0;
            rx_buf_q       <= '0;
            idx_q          <= '0;
            timer_q        <= '0;
            tx_crc_q       <= CRC_INIT;
            resp_valid_q   <= 1'b0;
            resp_payload_q <= '0;
            resp_crc_ok_q  <= 1'b0;
            resp_timeout_q <= 1'b0;
            sync_q         <= 2'b11;
`ifdef LINK_RESP_CRC_EN
            rx_crc_q       <= CRC_INIT;
            rx_rcv_q       <= 16'h0000;
`endif
        end else begin
            state_q        <= state_d;
            frame_n_q      <= frame_n_d;
            tx_start_q     <= tx_start_d;
            tx_data_q      <= tx_data_d;
            payload_q      <= payload_d;
            rx_buf_q       <= rx_buf_d;
            idx_q          <= idx_d;
            timer_q        <= timer_d;
            tx_crc_q       <= tx_crc_d;
            resp_valid_q   <= resp_valid_d;
            resp_payload_q <= resp_payload_d;
            resp_crc_ok_q  <= resp_crc_ok_d;
            resp_timeout_q <= resp_timeout_d;
            sync_q         <= {sync_q[0], resp_frame_n};
`ifdef LINK_RESP_CRC_EN
            rx_crc_q       <= rx_crc_d;
            rx_rcv_q       <= rx_rcv_d;
`endif
        end
    end

    assign cmd_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign frame_n      = frame_n_q;
    assign tx_start     = tx_start_q;
    assign tx_data      = tx_data_q;
    assign resp_valid   = resp_valid_q;
    assign resp_payload = resp_payload_q;
    assign resp_crc_ok  = resp_crc_ok_q;
    assign resp_timeout = resp_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_motor_link_master.sv
// ============================================================================
// Module  : tb_motor_link_master
// Brief   : Directed self-checking bench for motor_link_master with uart and
//           board models.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_motor_link_master;

    logic         CLK;
    logic         RST_N;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [127:0] cmd_payload;
    logic         frame_n;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic         tx_active;
    logic         tx_done;
    logic         rx_data_ready;
    logic [7:0]   rx_data;
    logic         resp_frame_n;
    logic         resp_valid;
    logic [127:0] resp_payload;
    logic         resp_crc_ok;
    logic         resp_timeout;
    logic         busy;

`ifdef LINK_RESP_CRC_EN
    localparam logic EXP_BAD_CRC_OK = 1'b0;
`else
    localparam logic EXP_BAD_CRC_OK = 1'b1;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] tx_log [$];
    int         start_cyc [$];
    int         last_done_cyc = 0;
    int         tx_err = 0;
    int         frame_err = 0;
    int         n_resp = 0;

    motor_link_master #(
        .PAYLOAD_BYTES  (16),
        .GUARD_CYCLES   (32),
        .TIMEOUT_CYCLES (16000)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_payload   (cmd_payload),
        .frame_n       (frame_n),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_active     (tx_active),
        .tx_done       (tx_done),
        .rx_data_ready (rx_data_ready),
        .rx_data       (rx_data),
        .resp_frame_n  (resp_frame_n),
        .resp_valid    (resp_valid),
        .resp_payload  (resp_payload),
        .resp_crc_ok   (resp_crc_ok),
        .resp_timeout  (resp_timeout),
        .busy          (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        forever begin
            @(posedge CLK);
            cyc = cyc + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // bit-serial reference, MSB of each byte first
    function automatic logic [15:0] crc_model(input logic [7:0] b [18], input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[15] ^ b[i][k];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    // uart_tx model: 160-cycle byte time, tx_done with tx_active falling
    initial begin : uart_tx_model
        int left;
        logic [7:0] cur;
        left = 0;
        cur = 8'h00;
        tx_active = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(negedge CLK);
            tx_done = 1'b0;
            if (tx_start) begin
                tx_log.push_back(tx_data);
                start_cyc.push_back(cyc);
                if (tx_active) tx_err = tx_err + 1;
                if (frame_n) frame_err = frame_err + 1;
                tx_active = 1'b1;
                left = 160;
                cur = tx_data;
            end else if (tx_active) begin
                left = left - 1;
                if (left == 0) begin
                    tx_active = 1'b0;
                    tx_done = 1'b1;
                    last_done_cyc = cyc;
                    if (busy && (tx_data != cur)) tx_err = tx_err + 1;
                    if (busy && frame_n) frame_err = frame_err + 1;
                end
            end
        end
    end

    initial begin : resp_counter
        forever begin
            @(negedge CLK);
            if (resp_valid) n_resp = n_resp + 1;
        end
    end

    task automatic do_command(input logic [127:0] pl, output int acc_cyc, output int rise_cyc);
        cmd_payload = pl;
        cmd_valid = 1'b1;
        acc_cyc = cyc;
        check_eq("pre_frame_n", frame_n, 1'b1);
        check_eq("pre_cmd_ready", cmd_ready, 1'b1);
        @(negedge CLK);
        cmd_valid = 1'b0;
        check_eq("frame_fall", frame_n, 1'b0);
        check_eq("busy_after_accept", busy, 1'b1);
        check_eq("cmd_ready_low", cmd_ready, 1'b0);
        rise_cyc = -1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge CLK);
            if (frame_n) begin
                rise_cyc = cyc;
                break;
            end
        end
        if (rise_cyc < 0) check_eq("frame_rise_wait", 1'b0, 1'b1);
    endtask

    task automatic board_reply(input int nbytes, input logic [7:0] fill, input bit corrupt, output int last_cyc);
        logic [7:0]  fr [18];
        logic [15:0] c;
        for (int i = 0; i < 18; i++) fr[i] = fill;
        c = crc_model(fr, 16);
        fr[16] = c[15:8];
        fr[17] = corrupt ? (c[7:0] ^ 8'h01) : c[7:0];
        repeat (200) @(negedge CLK);
        resp_frame_n = 1'b0;
        repeat (10) @(negedge CLK);
        last_cyc = cyc;
        for (int i = 0; i < nbytes; i++) begin
            rx_data = fr[i];
            rx_data_ready = 1'b1;
            last_cyc = cyc;
            @(negedge CLK);
            rx_data_ready = 1'b0;
            if (i != nbytes - 1) repeat (19) @(negedge CLK);
        end
    endtask

    task automatic wait_resp(input int budget, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (resp_valid) begin
                at_cyc = cyc;
                break;
            end
            @(negedge CLK);
        end
        if (at_cyc < 0) check_eq("resp_wait", 1'b0, 1'b1);
    endtask

    // caller is at negedge R+1 after the last byte at cycle R
    task automatic check_good_resp(input logic [127:0] exp_pl, input logic exp_ok);
        check_eq("resp_early", resp_valid, 1'b0);
        @(negedge CLK);
        check_eq("resp_valid_r2", resp_valid, 1'b1);
        check_eq("resp_crc_ok", resp_crc_ok, exp_ok);
        check_eq("resp_timeout_lo", resp_timeout, 1'b0);
        check_eq("resp_payload", resp_payload, exp_pl);
        check_eq("cmd_ready_in_done", cmd_ready, 1'b0);
        @(negedge CLK);
        check_eq("resp_pulse_1cyc", resp_valid, 1'b0);
        check_eq("cmd_ready_back", cmd_ready, 1'b1);
        resp_frame_n = 1'b1;
        repeat (5) @(negedge CLK);
    endtask

    initial begin : main
        logic [127:0] pl;
        logic [7:0]   txb [18];
        logic [15:0]  c;
        int acc, rise, last, at, base, nresp0;

        RST_N = 1'b0;
        cmd_valid = 1'b0;
        cmd_payload = '0;
        rx_data_ready = 1'b0;
        rx_data = 8'h00;
        resp_frame_n = 1'b1;
        repeat (3) @(negedge CLK);

        check_eq("rst_frame_n", frame_n, 1'b1);
        check_eq("rst_tx_start", tx_start, 1'b0);
        check_eq("rst_tx_data", tx_data, 8'h00);
        check_eq("rst_cmd_ready", cmd_ready, 1'b1);
        check_eq("rst_resp_valid", resp_valid, 1'b0);
        check_eq("rst_resp_payload", resp_payload, 128'h0);
        check_eq("rst_crc_ok", resp_crc_ok, 1'b0);
        check_eq("rst_timeout", resp_timeout, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);

        // 1: payload 0x00..0x0F, full send
        for (int j = 0; j < 16; j++) pl[8*j +: 8] = 8'(j);
        for (int j = 0; j < 18; j++) txb[j] = 8'(j);
        c = crc_model(txb, 16);
        base = tx_log.size();
        do_command(pl, acc, rise);
        check_eq("tx_count", 128'(tx_log.size() - base), 128'd18);
        if (tx_log.size() >= base + 18) begin
            for (int j = 0; j < 16; j++) check_eq("tx_payload_byte", tx_log[base + j], 8'(j));
            check_eq("tx_crc_hi", tx_log[base + 16], c[15:8]);
            check_eq("tx_crc_lo", tx_log[base + 17], c[7:0]);
            check_eq("first_start_guard", 128'((start_cyc[base] - acc) >= 33), 128'd1);
        end
        check_eq("trail_guard", 128'(rise - last_done_cyc), 128'd32);

        // 2: good reply of 0xAB
        board_reply(18, 8'hAB, 1'b0, last);
        check_good_resp({16{8'hAB}}, 1'b1);

        // 3: corrupted CRC low byte
        do_command(pl, acc, rise);
        board_reply(18, 8'hAB, 1'b1, last);
        check_good_resp({16{8'hAB}}, EXP_BAD_CRC_OK);

        // 4: no reply
        do_command(pl, acc, rise);
        wait_resp(17000, at);
        check_eq("noresp_latency", 128'(at - rise), 128'd16000);
        check_eq("noresp_timeout", resp_timeout, 1'b1);
        check_eq("noresp_crc_ok", resp_crc_ok, 1'b0);
        check_eq("noresp_payload_held", resp_payload, {16{8'hAB}});
        @(negedge CLK);
        check_eq("noresp_cmd_ready", cmd_ready, 1'b1);
        check_eq("noresp_pulse_1cyc", resp_valid, 1'b0);

        // 5: reply stalls after 10 bytes with frame held low
        do_command(pl, acc, rise);
        board_reply(10, 8'h11, 1'b0, last);
        wait_resp(17000, at);
        check_eq("gap_latency", 128'(at - last), 128'd16001);
        check_eq("gap_timeout", resp_timeout, 1'b1);
        check_eq("gap_payload_held", resp_payload, {16{8'hAB}});
        resp_frame_n = 1'b1;
        repeat (5) @(negedge CLK);

        // 6: frame released after 10 bytes
        do_command(pl, acc, rise);
        board_reply(10, 8'h22, 1'b0, last);
        repeat (4) @(negedge CLK);
        resp_frame_n = 1'b1;
        last = cyc;
        wait_resp(20, at);
        check_eq("early_rel_latency", 128'(at - last), 128'd3);
        check_eq("early_rel_timeout", resp_timeout, 1'b1);
        check_eq("early_rel_crc_ok", resp_crc_ok, 1'b0);
        repeat (5) @(negedge CLK);

        // 7: reset during byte 5 of the send, then a clean command
        base = tx_log.size();
        cmd_payload = pl;
        cmd_valid = 1'b1;
        @(negedge CLK);
        cmd_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (tx_log.size() >= base + 5) break;
            @(negedge CLK);
        end
        check_eq("rst_reach_byte5", 128'(tx_log.size() - base), 128'd5);
        repeat (50) @(negedge CLK);
        nresp0 = n_resp;
        #2;
        RST_N = 1'b0;
        #1;
        check_eq("async_rst_frame_n", frame_n, 1'b1);
        check_eq("async_rst_busy", busy, 1'b0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (400) @(negedge CLK);
        check_eq("rst_no_more_tx", 128'(tx_log.size() - base), 128'd5);
        check_eq("rst_no_resp", 128'(n_resp - nresp0), 128'd0);

        for (int j = 0; j < 16; j++) pl[8*j +: 8] = 8'(j * 17);
        for (int j = 0; j < 18; j++) txb[j] = 8'(j * 17);
        c = crc_model(txb, 16);
        base = tx_log.size();
        do_command(pl, acc, rise);
        check_eq("tx2_count", 128'(tx_log.size() - base), 128'd18);
        if (tx_log.size() >= base + 18) begin
            check_eq("tx2_byte3", tx_log[base + 3], 8'h33);
            check_eq("tx2_crc_hi", tx_log[base + 16], c[15:8]);
            check_eq("tx2_crc_lo", tx_log[base + 17], c[7:0]);
        end
        board_reply(18, 8'h5A, 1'b0, last);
        check_good_resp({16{8'h5A}}, 1'b1);

        check_eq("tx_protocol_errors", 128'(tx_err), 128'd0);
        check_eq("frame_low_errors", 128'(frame_err), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
